raster_scan_gen: RTL and testbench
==================================

Name: raster_scan_gen

Overview:
Parametrised pixel-coordinate generator that walks a frame of (x_last+1) by (y_last+1) points and emits one coordinate per accepted handshake.
- Frame size is runtime-configurable.
- Supports raster or serpentine order, single-shot or continuous frames, and downstream back-pressure via valid/ready.
- Feeds display/sprite pipelines that previously relied on a fixed 12x12 counter.

Parameters:
COORD_W, 4, bit width of x/y coordinates and of the x_last/y_last config.
FRAME_W, 8, width of the frame counter (wraps modulo 2^FRAME_W).

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  begin scan; sampled only in IDLE
stop  in  1  abort scan; sampled only in SCAN
x_last  in  COORD_W  last x index (frame width minus 1); latched on start
y_last  in  COORD_W  last y index (frame height minus 1); latched on start
serp  in  1  0 = raster, 1 = serpentine; latched on start
cont  in  1  0 = single frame, 1 = continuous; latched on start
ready  in  1  downstream accepts the current coordinate
valid  out  1  x/y hold a valid coordinate
x  out  COORD_W  current x
y  out  COORD_W  current y
sof  out  1  valid coordinate is first of frame
eol  out  1  valid coordinate is last of row
eof  out  1  valid coordinate is last of frame
busy  out  1  high in SCAN
done  out  1  one-cycle pulse after a single-shot frame completes
frame_cnt  out  FRAME_W  count of completed frames

Behaviour:
- Reset (async, any state): state=IDLE; x=0, y=0, valid=0, busy=0, done=0, frame_cnt=0. Configuration registers are cleared to 0.
- IDLE:
  - valid=0.
  - On start=1: latch x_last, y_last, serp, cont; x<=0, y<=0; go to SCAN. valid=1 from the next cycle (1-cycle latency start->first coordinate).
  - stop is ignored in IDLE.
- SCAN:
  - valid=1. x/y are stable while ready=0. Advance only when valid&ready (handshake).
  - Advance rule, raster: if x==x_last then x<=0, y<=y+1; else x<=x+1.
  - Advance rule, serpentine: even y counts x up 0..x_last; odd y counts x down x_last..0. At row end, y<=y+1 and x stays at the row-end value (x_last or 0), which is the first x of the next row.
  - Frame end: handshake at the eof coordinate.
    - cont=1: frame_cnt++, x<=0, y<=0, stay in SCAN with no bubble.
    - cont=0: frame_cnt++, go to IDLE, done=1 for exactly the next cycle (coincident with valid=0).
  - stop=1 in SCAN: go to IDLE at the next edge, valid=0, no done, frame_cnt unchanged. stop has priority over a simultaneous handshake, including the eof handshake.
  - start is ignored in SCAN. Config inputs changing mid-scan have no effect.
- Flags (combinational from registered state, gated by valid):
  - sof = (x==0 && y==0).
  - eol = (x==row-end x), where row-end x is x_last for raster and even serpentine rows, and 0 for odd serpentine rows.
  - eof = eol && y==y_last.
- Degenerate sizes:
  - x_last=0: every coordinate is eol; serpentine and raster are identical.
  - x_last=y_last=0: single 1x1 point; sof=eol=eof=1 together.
- Arithmetic: all counters are unsigned COORD_W bits; compare-before-increment, so no overflow. frame_cnt wraps silently.
- busy=1 exactly when state==SCAN.

Decomposition:
- Package raster_pkg: state enum {IDLE, SCAN}; mode constants RASTER=0, SERP=1; COORD_W default localparam.
- Sub-module scan_axis_cnt (COORD_W): loadable up/down counter with limit compare, at_end flag and step enable; instantiated once for x and once for y.
- FSM, flags and frame_cnt live in the top level.

Test Plan:
- Reset mid-SCAN at x=2,y=1 -> outputs immediately 0, valid=0, frame_cnt=0, state IDLE.
- Raster, x_last=3, y_last=2, ready=1, cont=0 -> 12 coordinates (0,0)..(3,2) in order. sof on the 1st, eol on the 4th/8th/12th, eof on the 12th. done pulses 1 cycle later; frame_cnt=1.
- Serpentine, x_last=2, y_last=1 -> sequence (0,0)(1,0)(2,0)(2,1)(1,1)(0,1); eol at (2,0) and (0,1).
- Back-pressure: ready toggled 1,0,0,1 in raster 4x1 -> x holds at 1 for the stalled cycles. The 4 coordinates are each accepted exactly once.
- Continuous, x_last=y_last=0, ready=1 for 5 cycles -> sof=eol=eof=1 every cycle; frame_cnt counts 1..5; no done.
- stop asserted coincident with the eof handshake (cont=0) -> IDLE next cycle, done=0, frame_cnt unchanged. Following start restarts at (0,0).

Source files
------------

// File: rtl/raster_pkg.sv
// Shared types and constants for the raster scan generator.
// Holds the FSM state enum, scan-order modes and coordinate width default.
package raster_pkg;

    localparam int COORD_W_DEF = 4;
    localparam int FRAME_W_DEF = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic RASTER = 1'b0;
    localparam logic SERP   = 1'b1;

    // x counts down only on odd rows of a serpentine scan
    function automatic logic x_counts_up(logic mode, logic odd_row);
        return !(mode == SERP && odd_row);
    endfunction

endpackage

// File: rtl/scan_axis_cnt.sv
// Loadable up/down axis counter with end-of-axis compare.
// at_end_o compares against limit when counting up and zero when counting down.
module scan_axis_cnt
    import raster_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic [COORD_W-1:0] load_val_i,
    input  logic               step_i,
    input  logic               up_i,
    input  logic [COORD_W-1:0] limit_i,
    output logic [COORD_W-1:0] cnt_o,
    output logic               at_end_o
);

    logic [COORD_W-1:0] cnt_q;
    logic [COORD_W-1:0] cnt_d;

    // next count: load wins over a step
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (step_i) begin
            if (up_i) begin
                cnt_d = cnt_q + COORD_W'(1);
            end else begin
                cnt_d = cnt_q - COORD_W'(1);
            end
        end
    end

    // count register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o    = cnt_q;
    assign at_end_o = up_i ? (cnt_q == limit_i) : (cnt_q == '0);

endmodule

// File: rtl/raster_scan_gen.sv
// Frame coordinate generator: raster or serpentine walk with valid/ready.
// Single-shot or continuous frames; frame counter wraps silently.
module raster_scan_gen
    import raster_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF,
    parameter int FRAME_W = FRAME_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic [COORD_W-1:0] x_last,
    input  logic [COORD_W-1:0] y_last,
    input  logic               serp,
    input  logic               cont,
    input  logic               ready,
    output logic               valid,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               sof,
    output logic               eol,
    output logic               eof,
    output logic               busy,
    output logic               done,
    output logic [FRAME_W-1:0] frame_cnt
);

    state_t             state_q, state_d;
    logic [COORD_W-1:0] xl_q, xl_d;
    logic [COORD_W-1:0] yl_q, yl_d;
    logic               serp_q, serp_d;
    logic               cont_q, cont_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               done_q, done_d;

    logic               x_load, x_step, x_up, x_end;
    logic               y_load, y_step, y_end;
    logic [COORD_W-1:0] x_cnt, y_cnt;
    logic               hs;
    logic               at_eof;

    assign x_up   = x_counts_up(serp_q, y_cnt[0]);
    assign hs     = (state_q == SCAN) && ready;
    assign at_eof = x_end && y_end;

    scan_axis_cnt #(.COORD_W(COORD_W)) u_x (
        .clk        (clk),
        .reset      (reset),
        .load_i     (x_load),
        .load_val_i ('0),
        .step_i     (x_step),
        .up_i       (x_up),
        .limit_i    (xl_q),
        .cnt_o      (x_cnt),
        .at_end_o   (x_end)
    );

    scan_axis_cnt #(.COORD_W(COORD_W)) u_y (
        .clk        (clk),
        .reset      (reset),
        .load_i     (y_load),
        .load_val_i ('0),
        .step_i     (y_step),
        .up_i       (1'b1),
        .limit_i    (yl_q),
        .cnt_o      (y_cnt),
        .at_end_o   (y_end)
    );

    // next state, config latch, counter controls and frame bookkeeping
    always_comb begin
        state_d = state_q;
        xl_d    = xl_q;
        yl_d    = yl_q;
        serp_d  = serp_q;
        cont_d  = cont_q;
        frame_d = frame_q;
        done_d  = 1'b0;
        x_load  = 1'b0;
        x_step  = 1'b0;
        y_load  = 1'b0;
        y_step  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    xl_d    = x_last;
                    yl_d    = y_last;
                    serp_d  = serp;
                    cont_d  = cont;
                    x_load  = 1'b1;
                    y_load  = 1'b1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (hs) begin
                    if (at_eof) begin
                        frame_d = frame_q + FRAME_W'(1);
                        x_load  = 1'b1;
                        y_load  = 1'b1;
                        if (!cont_q) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else if (x_end) begin
                        y_step = 1'b1;
                        // serpentine keeps x: row end is next row's start
                        x_load = (serp_q == RASTER);
                    end else begin
                        x_step = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // state, configuration and status registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            xl_q    <= '0;
            yl_q    <= '0;
            serp_q  <= 1'b0;
            cont_q  <= 1'b0;
            frame_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            xl_q    <= xl_d;
            yl_q    <= yl_d;
            serp_q  <= serp_d;
            cont_q  <= cont_d;
            frame_q <= frame_d;
            done_q  <= done_d;
        end
    end

    assign valid     = (state_q == SCAN);
    assign busy      = (state_q == SCAN);
    assign x         = x_cnt;
    assign y         = y_cnt;
    assign sof       = valid && (x_cnt == '0) && (y_cnt == '0);
    assign eol       = valid && x_end;
    assign eof       = valid && at_eof;
    assign done      = done_q;
    assign frame_cnt = frame_q;

endmodule

// File: tb/tb_raster_scan_gen.sv
// Self-checking bench for raster_scan_gen: directed scenarios plus random
// traffic compared every cycle against a frame-index reference model.
module tb_raster_scan_gen;

    localparam int CW = 4;
    localparam int FW = 8;

    logic          clk = 1'b0;
    logic          reset, start, stop, serp, cont, ready;
    logic [CW-1:0] x_last, y_last;
    logic          valid, sof, eol, eof, busy, done;
    logic [CW-1:0] x, y;
    logic [FW-1:0] frame_cnt;

    always #5 clk = ~clk;

    raster_scan_gen #(.COORD_W(CW), .FRAME_W(FW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .x_last    (x_last),
        .y_last    (y_last),
        .serp      (serp),
        .cont      (cont),
        .ready     (ready),
        .valid     (valid),
        .x         (x),
        .y         (y),
        .sof       (sof),
        .eol       (eol),
        .eof       (eof),
        .busy      (busy),
        .done      (done),
        .frame_cnt (frame_cnt)
    );

    // reference model: position is an index k into the frame
    bit m_scan, m_done, m_serp, m_cont;
    int m_k, m_xl, m_yl, m_fc;

    int n_chk = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    typedef struct {
        int x;
        int y;
        bit sof;
        bit eol;
        bit eof;
    } acc_t;
    acc_t acc_q[$];

    task automatic check(string name, int got, int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    endtask

    function automatic int flen();
        return (m_xl + 1) * (m_yl + 1);
    endfunction

    function automatic int ex_x(int k);
        int col, row;
        col = k % (m_xl + 1);
        row = k / (m_xl + 1);
        return (m_serp && (row % 2 == 1)) ? (m_xl - col) : col;
    endfunction

    function automatic int ex_y(int k);
        return k / (m_xl + 1);
    endfunction

    task automatic model_reset();
        m_scan = 0; m_done = 0; m_serp = 0; m_cont = 0;
        m_k = 0; m_xl = 0; m_yl = 0; m_fc = 0;
    endtask

    task automatic model_step();
        if (reset) begin
            model_reset();
        end else begin
            m_done = 0;
            if (!m_scan) begin
                if (start) begin
                    m_xl = int'(x_last);
                    m_yl = int'(y_last);
                    m_serp = serp;
                    m_cont = cont;
                    m_k = 0;
                    m_scan = 1;
                end
            end else if (stop) begin
                m_scan = 0;
            end else if (ready) begin
                if (m_k == flen() - 1) begin
                    m_fc = (m_fc + 1) % (1 << FW);
                    m_k = 0;
                    if (!m_cont) begin
                        m_scan = 0;
                        m_done = 1;
                    end
                end else begin
                    m_k++;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        acc_q.delete();
    endtask

    // per-cycle compare against the model; also log accepted coordinates
    always @(negedge clk) begin
        if (chk_en && !reset) begin
            check("valid", int'(valid), int'(m_scan));
            check("busy", int'(busy), int'(m_scan));
            check("done", int'(done), int'(m_done));
            check("frame_cnt", int'(frame_cnt), m_fc);
            if (m_scan) begin
                check("x", int'(x), ex_x(m_k));
                check("y", int'(y), ex_y(m_k));
                check("sof", int'(sof), int'(m_k == 0));
                check("eol", int'(eol), int'((m_k % (m_xl + 1)) == m_xl));
                check("eof", int'(eof), int'(m_k == flen() - 1));
            end else begin
                check("flags_idle", int'({sof, eol, eof}), 0);
            end
            if (valid && ready)
                acc_q.push_back('{int'(x), int'(y), sof, eol, eof});
        end
    end

    int sx[6];
    int sy[6];
    int bp[6];
    int ne;

    initial begin
        model_reset();
        reset = 1'b1; start = 0; stop = 0; serp = 0; cont = 0; ready = 0;
        x_last = '0; y_last = '0;
        tick();
        tick();
        check("rst_valid", int'(valid), 0);
        check("rst_xy", int'({x, y}), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_fcnt", int'(frame_cnt), 0);
        reset = 1'b0;
        chk_en = 1'b1;

        // raster 4x3 single shot
        acc_q.delete();
        x_last = 3; y_last = 2; serp = 0; cont = 0; ready = 1; start = 1;
        tick();
        start = 0;
        repeat (12) tick();
        check("r_done", int'(done), 1);
        check("r_fcnt", int'(frame_cnt), 1);
        check("r_count", acc_q.size(), 12);
        if (acc_q.size() == 12) begin
            ne = 0;
            foreach (acc_q[i]) ne += int'(acc_q[i].eol);
            check("r_eol_n", ne, 3);
            check("r_sof0", int'(acc_q[0].sof), 1);
            check("r_eol3", int'(acc_q[3].eol), 1);
            check("r_eol7", int'(acc_q[7].eol), 1);
            check("r_eof11", int'(acc_q[11].eof), 1);
            check("r_last_x", acc_q[11].x, 3);
            check("r_last_y", acc_q[11].y, 2);
            check("r_x5", acc_q[5].x, 1);
            check("r_y5", acc_q[5].y, 1);
        end
        tick();
        check("r_done_pulse", int'(done), 0);

        // serpentine 3x2
        acc_q.delete();
        sx = '{0, 1, 2, 2, 1, 0};
        sy = '{0, 0, 0, 1, 1, 1};
        x_last = 2; y_last = 1; serp = 1; start = 1;
        tick();
        start = 0;
        repeat (6) tick();
        check("s_count", acc_q.size(), 6);
        if (acc_q.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                check("s_x", acc_q[i].x, sx[i]);
                check("s_y", acc_q[i].y, sy[i]);
                check("s_eol", int'(acc_q[i].eol), int'(i == 2 || i == 5));
            end
        end

        // back-pressure, raster 4x1
        acc_q.delete();
        bp = '{1, 0, 0, 1, 1, 1};
        x_last = 3; y_last = 0; serp = 0; start = 1;
        tick();
        start = 0;
        for (int i = 0; i < 6; i++) begin
            ready = bp[i][0];
            tick();
            if (i < 3) check("bp_hold_x", int'(x), 1);
        end
        check("bp_done", int'(done), 1);
        check("bp_count", acc_q.size(), 4);
        if (acc_q.size() == 4)
            for (int i = 0; i < 4; i++) check("bp_x", acc_q[i].x, i);

        // continuous 1x1, then stop overriding the eof handshake
        do_reset();
        x_last = 0; y_last = 0; cont = 1; ready = 1; start = 1;
        tick();
        start = 0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("c_fcnt", int'(frame_cnt), i);
            check("c_flags", int'({sof, eol, eof}), 7);
            check("c_nodone", int'(done), 0);
        end
        stop = 1;
        tick();
        stop = 0;
        check("c_stop_valid", int'(valid), 0);
        check("c_stop_fcnt", int'(frame_cnt), 5);

        // stop coincident with single-shot eof handshake
        do_reset();
        x_last = 1; y_last = 0; cont = 0; ready = 1; start = 1;
        tick();
        start = 0;
        tick();
        check("e_at_eof", int'(eof), 1);
        stop = 1;
        tick();
        stop = 0;
        check("e_valid", int'(valid), 0);
        check("e_done", int'(done), 0);
        check("e_fcnt", int'(frame_cnt), 0);
        start = 1;
        tick();
        start = 0;
        check("e_restart_v", int'(valid), 1);
        check("e_restart_xy", int'({x, y}), 0);
        check("e_restart_sof", int'(sof), 1);

        // async reset mid-scan at (2,1)
        do_reset();
        x_last = 3; y_last = 2; serp = 0; cont = 0; ready = 1; start = 1;
        tick();
        start = 0;
        repeat (6) tick();
        check("m_x", int'(x), 2);
        check("m_y", int'(y), 1);
        reset = 1'b1;
        #1;
        check("m_rst_valid", int'(valid), 0);
        check("m_rst_xy", int'({x, y}), 0);
        check("m_rst_busy", int'(busy), 0);
        check("m_rst_fcnt", int'(frame_cnt), 0);
        model_reset();
        tick();
        reset = 1'b0;

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom % 4) == 0;
            stop = ($urandom % 30) == 0;
            ready = ($urandom % 10) < 7;
            serp = $urandom % 2;
            cont = $urandom % 2;
            x_last = ($urandom % 8 == 0) ? CW'($urandom) : CW'($urandom_range(0, 4));
            y_last = ($urandom % 8 == 0) ? CW'($urandom) : CW'($urandom_range(0, 4));
            reset = ($urandom % 700) == 0;
            tick();
        end
        reset = 1'b0;
        tick();
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
